dma_tx_msi_sched: RTL and testbench

MSI interrupt scheduler for the LLDMA TX path. It collects per-channel interrupt kicks from the DMA TX channels and coalesces repeat kicks per channel. It shares the single PCIe MSI request port among channels by round-robin. It sequences each request through the PCI_TRX sent/fail handshake, with bounded retry and a response timeout.

---
 rtl/dma_tx_msi_sched.sv | 136 +++++++++++++
 tb/tb_dma_tx_msi_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_tx_msi_sched.sv
// MSI scheduler for the LLDMA TX path: coalesces per-channel kicks, shares the
// single MSI request port by round-robin and runs the sent/fail handshake.
module dma_tx_msi_sched #(
  parameter int CH_NUM    = 4,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic              user_clk,
  input  logic              reset,
  input  logic [CH_NUM-1:0] int_kick,
  input  logic              int_msi_enb,
  input  logic              int_msi_sent,
  input  logic              int_msi_fail,
  output logic [31:0]       msi_int_user,
  output logic [CH_NUM-1:0] ch_pending,
  output logic [CH_NUM-1:0] ch_err,
  input  logic [CH_NUM-1:0] err_clr,
  output logic              msi_busy
);
  localparam int PW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [PW-1:0] LAST_CH   = PW'(CH_NUM-1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [7:0]    BO_LAST   = 8'(BACKOFF-1);
  localparam logic [15:0]   TMO_LAST  = 16'(TIMEOUT-1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_BACKOFF, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     grant, grant_nxt, rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]     sel, hi_sel, lo_sel;
  logic              hi_found;
  logic [3:0]        retry_cnt, retry_nxt;
  logic [7:0]        bo_cnt, bo_nxt;
  logic [15:0]       tmo_cnt, tmo_nxt;
  logic [CH_NUM-1:0] pend_nxt, err_nxt, done_mask, err_set;
  logic [31:0]       msi_nxt;

  // Round-robin: lowest pending channel at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int i = CH_NUM-1; i >= 0; i--) begin
      if (ch_pending[i]) begin
        lo_sel = PW'(i);
        if (PW'(i) >= rr_ptr) begin
          hi_sel   = PW'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    retry_nxt  = retry_cnt;
    bo_nxt     = bo_cnt;
    tmo_nxt    = tmo_cnt;
    done_mask  = '0;
    err_set    = '0;
    case (state)
      S_IDLE: begin
        if (int_msi_enb && |ch_pending) begin
          grant_nxt = sel;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (tmo_cnt != TMO_LAST) tmo_nxt = tmo_cnt + 16'd1;
        if (int_msi_sent) begin
          done_mask[grant] = 1'b1;
          retry_nxt        = '0;
          state_nxt        = S_GAP;
        end else if (int_msi_fail || tmo_cnt == TMO_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_nxt = retry_cnt + 4'd1;
            bo_nxt    = '0;
            state_nxt = S_BACKOFF;
          end else begin
            done_mask[grant] = 1'b1;
            err_set[grant]   = 1'b1;
            retry_nxt        = '0;
            state_nxt        = S_GAP;
          end
        end
      end
      S_BACKOFF: begin
        // Grant is held across the back-off; the re-issue waits for enable.
        if (bo_cnt != BO_LAST) bo_nxt = bo_cnt + 8'd1;
        else if (int_msi_enb)  state_nxt = S_ISSUE;
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (|done_mask) rr_ptr_nxt = (grant == LAST_CH) ? '0 : grant + PW'(1);
    // A kick coincident with sent/drop re-arms the channel.
    pend_nxt = (ch_pending & ~done_mask) | int_kick;
    err_nxt  = (ch_err & ~err_clr) | err_set;
    msi_nxt  = (state_nxt == S_ISSUE) ? (32'd1 << grant_nxt) : 32'd0;
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state        <= S_IDLE;
      grant        <= '0;
      rr_ptr       <= '0;
      retry_cnt    <= '0;
      bo_cnt       <= '0;
      tmo_cnt      <= '0;
      ch_pending   <= '0;
      ch_err       <= '0;
      msi_int_user <= '0;
      msi_busy     <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      rr_ptr       <= rr_ptr_nxt;
      retry_cnt    <= retry_nxt;
      bo_cnt       <= bo_nxt;
      tmo_cnt      <= tmo_nxt;
      ch_pending   <= pend_nxt;
      ch_err       <= err_nxt;
      msi_int_user <= msi_nxt;
      msi_busy     <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_dma_tx_msi_sched.sv
// Bench for dma_tx_msi_sched: directed timing scenarios plus randomized rounds
// checked against a pending-set / round-robin order model.
module tb_dma_tx_msi_sched;
  localparam int CH = 4;

  logic          user_clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] int_kick = '0;
  logic          int_msi_enb = 1'b1;
  logic          int_msi_sent = 1'b0;
  logic          int_msi_fail = 1'b0;
  logic [31:0]   msi_int_user;
  logic [CH-1:0] ch_pending;
  logic [CH-1:0] ch_err;
  logic [CH-1:0] err_clr = '0;
  logic          msi_busy;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;

  dma_tx_msi_sched #(.CH_NUM(CH), .MAX_RETRY(3), .BACKOFF(16), .TIMEOUT(1024)) dut (
    .user_clk(user_clk), .reset(reset), .int_kick(int_kick), .int_msi_enb(int_msi_enb),
    .int_msi_sent(int_msi_sent), .int_msi_fail(int_msi_fail), .msi_int_user(msi_int_user),
    .ch_pending(ch_pending), .ch_err(ch_err), .err_clr(err_clr), .msi_busy(msi_busy));

  always #5 user_clk = ~user_clk;

  task automatic step();
    @(posedge user_clk);
    #1;
    cyc++;
  endtask

  task automatic wait_pulse(input int budget, output logic [31:0] v, output int at, output bit ok);
    ok = 1'b0; v = '0; at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (msi_int_user != 32'd0) begin
        v = msi_int_user; at = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_sent();
    step();
    int_msi_sent = 1'b1; step(); int_msi_sent = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    ncmp++; if (msi_int_user !== 32'd0) begin nfail++; $display("FAIL reset_msi: got %0h want 0", msi_int_user); end
    ncmp++; if (ch_pending !== '0) begin nfail++; $display("FAIL reset_pending: got %0h want 0", ch_pending); end
    ncmp++; if (ch_err !== '0) begin nfail++; $display("FAIL reset_err: got %0h want 0", ch_err); end
    ncmp++; if (msi_busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %0b want 0", msi_busy); end
  endtask

  task automatic test_single();
    int p, k, extra;
    int_kick = 4'b0010; step(); int_kick = '0;
    ncmp++; if (ch_pending !== 4'b0010) begin nfail++; $display("FAIL single_pend: got %0h want 2", ch_pending); end
    ncmp++; if (msi_int_user !== 32'd0) begin nfail++; $display("FAIL single_early: got %0h want 0", msi_int_user); end
    step();
    p = cyc;
    ncmp++; if (msi_int_user !== 32'h2) begin nfail++; $display("FAIL single_pulse: got %0h want 2", msi_int_user); end
    ncmp++; if (msi_busy !== 1'b1) begin nfail++; $display("FAIL single_busy: got %0b want 1", msi_busy); end
    extra = 0;
    for (int i = 0; i < 5; i++) begin step(); if (msi_int_user != 32'd0) extra++; end
    ncmp++; if (extra !== 0) begin nfail++; $display("FAIL single_onecycle: got %0d extra pulse cycles want 0", extra); end
    k = cyc;
    int_msi_sent = 1'b1; step(); int_msi_sent = 1'b0;
    ncmp++; if (ch_pending !== 4'b0000) begin nfail++; $display("FAIL single_clear: got %0h want 0 at k+1", ch_pending); end
    ncmp++; if (msi_busy !== 1'b1) begin nfail++; $display("FAIL single_gap_busy: got %0b want 1", msi_busy); end
    step();
    ncmp++; if (msi_busy !== 1'b0) begin nfail++; $display("FAIL single_idle: got %0b want 0 at k+2 (k=%0d p=%0d)", msi_busy, k, p); end
  endtask

  task automatic test_rr_coalesce();
    logic [31:0] v;
    int at, k, extra;
    bit ok;
    reset = 1'b1; step(); reset = 1'b0;
    int_kick = 4'hF; step(); int_kick = '0;
    k = -1;
    for (int n = 0; n < 4; n++) begin
      wait_pulse(20, v, at, ok);
      ncmp++; if (!ok || v !== (32'd1 << n)) begin nfail++; $display("FAIL rr_order%0d: got %0h want %0h", n, v, 32'd1 << n); end
      if (n > 0) begin
        ncmp++; if (at - k !== 3) begin nfail++; $display("FAIL rr_spacing%0d: got %0d want 3", n, at - k); end
      end
      for (int d = 0; d < 3; d++) begin
        if (n == 0) int_kick = 4'b0100;
        step();
        int_kick = '0;
      end
      k = cyc;
      int_msi_sent = 1'b1; step(); int_msi_sent = 1'b0;
    end
    extra = 0;
    for (int i = 0; i < 25; i++) begin step(); if (msi_int_user != 32'd0) extra++; end
    ncmp++; if (extra !== 0) begin nfail++; $display("FAIL rr_coalesce: got %0d extra pulses want 0", extra); end
    ncmp++; if (ch_pending !== '0) begin nfail++; $display("FAIL rr_pend_end: got %0h want 0", ch_pending); end
  endtask

  task automatic test_retry();
    logic [31:0] v;
    int at, f;
    bit ok;
    int_kick = 4'b0001; step(); int_kick = '0;
    wait_pulse(10, v, at, ok);
    ncmp++; if (!ok || v !== 32'h1) begin nfail++; $display("FAIL retry_p0: got %0h want 1", v); end
    for (int n = 1; n < 3; n++) begin
      step();
      f = cyc;
      int_msi_fail = 1'b1; step(); int_msi_fail = 1'b0;
      wait_pulse(40, v, at, ok);
      ncmp++; if (!ok || v !== 32'h1 || at - f !== 17) begin
        nfail++; $display("FAIL retry_p%0d: got %0h after %0d want 1 after 17", n, v, at - f);
      end
    end
    step();
    int_msi_sent = 1'b1; step(); int_msi_sent = 1'b0;
    ncmp++; if (ch_pending !== '0) begin nfail++; $display("FAIL retry_pend: got %0h want 0", ch_pending); end
    ncmp++; if (ch_err !== '0) begin nfail++; $display("FAIL retry_err: got %0h want 0", ch_err); end
    step(); step();
  endtask

  task automatic test_drop();
    logic [31:0] v;
    logic [CH-1:0] gm;
    int at, f, g, extra;
    bit ok;
    g = $urandom_range(0, CH-1);
    gm = CH'(1) << g;
    int_kick = gm; step(); int_kick = '0;
    f = -1;
    for (int n = 0; n < 4; n++) begin
      wait_pulse(40, v, at, ok);
      ncmp++; if (!ok || v !== (32'd1 << g) || (n > 0 && at - f !== 17)) begin
        nfail++; $display("FAIL drop_p%0d: got %0h after %0d want %0h", n, v, at - f, 32'd1 << g);
      end
      step();
      f = cyc;
      if (n == 3) err_clr = gm;
      int_msi_fail = 1'b1; step(); int_msi_fail = 1'b0; err_clr = '0;
    end
    ncmp++; if (ch_err !== gm) begin nfail++; $display("FAIL drop_err_set: got %0h want %0h", ch_err, gm); end
    ncmp++; if (ch_pending !== '0) begin nfail++; $display("FAIL drop_pend: got %0h want 0", ch_pending); end
    extra = 0;
    for (int i = 0; i < 30; i++) begin step(); if (msi_int_user != 32'd0) extra++; end
    ncmp++; if (extra !== 0) begin nfail++; $display("FAIL drop_no5th: got %0d pulses want 0", extra); end
    ncmp++; if (ch_err !== gm) begin nfail++; $display("FAIL drop_err_sticky: got %0h want %0h", ch_err, gm); end
    err_clr = gm; step(); err_clr = '0;
    ncmp++; if (ch_err !== '0) begin nfail++; $display("FAIL drop_err_clr: got %0h want 0", ch_err); end
  endtask

  task automatic test_timeout_enb();
    logic [31:0] v;
    int at, e, t, extra;
    bit ok;
    int_msi_enb = 1'b0;
    int_kick = 4'b1000; step(); int_kick = '0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin step(); if (msi_int_user != 32'd0) extra++; end
    ncmp++; if (extra !== 0) begin nfail++; $display("FAIL enb_gate: got %0d pulses want 0", extra); end
    ncmp++; if (ch_pending !== 4'b1000 || msi_busy !== 1'b0) begin
      nfail++; $display("FAIL enb_hold: got pend %0h busy %0b want 8/0", ch_pending, msi_busy);
    end
    e = cyc;
    int_msi_enb = 1'b1;
    wait_pulse(5, v, at, ok);
    ncmp++; if (!ok || v !== 32'h8 || at !== e + 1) begin
      nfail++; $display("FAIL enb_pulse: got %0h at +%0d want 8 at +1", v, at - e);
    end
    t = at;
    step();
    int_msi_enb = 1'b0;
    for (int i = 0; i < 100; i++) step();
    int_msi_enb = 1'b1;
    wait_pulse(1100, v, at, ok);
    ncmp++; if (!ok || v !== 32'h8 || at !== t + 1041) begin
      nfail++; $display("FAIL timeout_reissue: got %0h at +%0d want 8 at +1041", v, at - t);
    end
    finish_sent();
    ncmp++; if (ch_pending !== '0 || ch_err !== '0) begin
      nfail++; $display("FAIL timeout_end: got pend %0h err %0h want 0/0", ch_pending, ch_err);
    end
  endtask

  task automatic test_reset_race();
    logic [31:0] v;
    int at, k, extra;
    bit ok;
    int_kick = 4'b0001; step(); int_kick = '0;
    wait_pulse(10, v, at, ok);
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    ncmp++; if (msi_int_user !== 32'd0 || ch_pending !== '0 || ch_err !== '0 || msi_busy !== 1'b0) begin
      nfail++; $display("FAIL reset_wait: got msi %0h pend %0h err %0h busy %0b want all 0",
                        msi_int_user, ch_pending, ch_err, msi_busy);
    end
    int_msi_sent = 1'b1; step(); int_msi_sent = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin step(); if (msi_int_user != 32'd0 || msi_busy) extra++; end
    ncmp++; if (extra !== 0) begin nfail++; $display("FAIL reset_sent_ignored: got %0d active cycles want 0", extra); end
    int_kick = 4'b0010; step(); int_kick = '0;
    wait_pulse(10, v, at, ok);
    ncmp++; if (!ok || v !== 32'h2) begin nfail++; $display("FAIL race_p0: got %0h want 2", v); end
    step(); step();
    k = cyc;
    int_msi_sent = 1'b1; int_kick = 4'b0010; step(); int_msi_sent = 1'b0; int_kick = '0;
    ncmp++; if (ch_pending !== 4'b0010) begin nfail++; $display("FAIL race_pend: got %0h want 2", ch_pending); end
    wait_pulse(10, v, at, ok);
    ncmp++; if (!ok || v !== 32'h2 || at !== k + 3) begin
      nfail++; $display("FAIL race_p1: got %0h at +%0d want 2 at +3", v, at - k);
    end
    finish_sent();
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [CH-1:0] rem, failed;
    int at, rr, ch, d, extra, guard;
    bit ok;
    reset = 1'b1; step(); reset = 1'b0;
    rr = 0;
    for (int r = 0; r < 12; r++) begin
      rem = CH'($urandom_range(1, 15));
      failed = '0;
      int_kick = rem; step(); int_kick = '0;
      guard = 0;
      while (rem != '0 && guard < 12) begin
        guard++;
        ch = 0;
        for (int i = CH-1; i >= 0; i--) if (rem[(rr + i) % CH]) ch = (rr + i) % CH;
        wait_pulse(40, v, at, ok);
        ncmp++; if (!ok || v !== (32'd1 << ch)) begin
          nfail++; $display("FAIL rand_r%0d: got %0h want %0h", r, v, 32'd1 << ch);
        end
        d = $urandom_range(1, 6);
        for (int i = 0; i < d; i++) begin
          int_kick = ($urandom_range(0, 1) == 1) ? (rem & CH'($urandom_range(0, 15))) : '0;
          step();
          int_kick = '0;
        end
        if (!failed[ch] && $urandom_range(0, 2) == 0) begin
          failed[ch] = 1'b1;
          int_msi_fail = 1'b1; step(); int_msi_fail = 1'b0;
        end else begin
          int_msi_sent = 1'b1; step(); int_msi_sent = 1'b0;
          rem[ch] = 1'b0;
          rr = (ch + 1) % CH;
        end
      end
      extra = 0;
      for (int i = 0; i < 15; i++) begin step(); if (msi_int_user != 32'd0) extra++; end
      ncmp++; if (extra !== 0 || ch_pending !== '0 || ch_err !== '0) begin
        nfail++; $display("FAIL rand_end_r%0d: got %0d extra pulses pend %0h err %0h want 0/0/0",
                          r, extra, ch_pending, ch_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_coalesce();
    test_retry();
    test_drop();
    test_timeout_enb();
    test_reset_race();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
